// File: rtl/mc_controlunit.sv
// Multi-cycle MIPS control unit: FSM plus MDU cycle counter; strobes decode from state and class.
// Optional exception support (syscall/break/unknown -> EXC, eret) under `MC_CONTROLUNIT_EXC_EN.
module mc_controlunit #(
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       negative,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic [2:0] state,
  output logic       pc_we,
  output logic       ir_we,
  output logic       wrf,
  output logic       wena,
  output logic       hilo_we,
  output logic       mdu_start,
  output logic       exc,
  output logic       busy
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StMdu    = 3'd5,
    StExc    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsLoad, ClsStore, ClsJump, ClsLink, ClsBranch,
    ClsHiLo, ClsMtc0, ClsMdu, ClsEret, ClsTrap, ClsBad
  } cls_e;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MDU_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_e             cls;
  logic             taken;

  always_comb begin
    cls = ClsBad;
    unique case (op)
      6'h00: begin
        case (func)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b:                  cls = ClsAlu;
          6'h08:                         cls = ClsJump;
          6'h09:                         cls = ClsLink;
          6'h0c, 6'h0d:                  cls = ClsTrap;
          6'h11, 6'h13:                  cls = ClsHiLo;
          6'h18, 6'h19, 6'h1a, 6'h1b:    cls = ClsMdu;
          default:                       cls = ClsBad;
        endcase
      end
      6'h01:                             cls = (rt == 5'd0 || rt == 5'd1) ? ClsBranch : ClsBad;
      6'h02:                             cls = ClsJump;
      6'h03:                             cls = ClsLink;
      6'h04, 6'h05, 6'h06, 6'h07:        cls = ClsBranch;
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e, 6'h0f:        cls = ClsAlu;
      6'h10: begin
        if (rs == 5'h00)                         cls = ClsAlu;
        else if (rs == 5'h04)                    cls = ClsMtc0;
        else if (rs == 5'h10 && func == 6'h18)   cls = ClsEret;
        else                                     cls = ClsBad;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls = ClsLoad;
      6'h28, 6'h29, 6'h2b:               cls = ClsStore;
      default:                           cls = ClsBad;
    endcase
  end

  // regimm: rt=0 is bltz, rt=1 is bgez
  always_comb begin
    taken = 1'b0;
    case (op)
      6'h01:   taken = (rt == 5'd0) ? (!zero && negative) : (zero || !negative);
      6'h04:   taken = zero;
      6'h05:   taken = !zero;
      6'h06:   taken = zero || negative;
      6'h07:   taken = !zero && !negative;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    wrf       = 1'b0;
    wena      = 1'b0;
    hilo_we   = 1'b0;
    mdu_start = 1'b0;
    exc       = 1'b0;
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (cls)
          ClsMdu: begin
            state_d = StMdu;
            cnt_d   = CntLoad;
          end
`ifdef MC_CONTROLUNIT_EXC_EN
          ClsTrap, ClsBad: state_d = StExc;
          ClsEret:         state_d = StExec;
`else
          ClsTrap, ClsBad, ClsEret: state_d = StFetch;
`endif
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        state_d = StFetch;
        case (cls)
          ClsAlu:            state_d = StWb;
          ClsLoad, ClsStore: state_d = StMem;
          ClsJump:           pc_we = 1'b1;
          ClsLink: begin
            pc_we   = 1'b1;
            state_d = StWb;
          end
          ClsBranch:         pc_we = taken;
          ClsHiLo:           hilo_we = 1'b1;
`ifdef MC_CONTROLUNIT_EXC_EN
          ClsEret:           pc_we = 1'b1;
`endif
          default:           state_d = StFetch;
        endcase
      end
      StMem: begin
        wena = (cls == ClsStore);
        if (dmem_ready) state_d = (cls == ClsStore) ? StFetch : StWb;
      end
      StWb: begin
        wrf     = 1'b1;
        state_d = StFetch;
      end
      StMdu: begin
        // counter only equals the load value in the first MDU cycle
        mdu_start = (cnt_q == CntLoad);
        if (cnt_q == '0) begin
          hilo_we = 1'b1;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StExc: begin
`ifdef MC_CONTROLUNIT_EXC_EN
        exc   = 1'b1;
        pc_we = 1'b1;
`endif
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (rst) begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      wrf       = 1'b0;
      wena      = 1'b0;
      hilo_we   = 1'b0;
      mdu_start = 1'b0;
      exc       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign busy  = (state_q == StMdu);

endmodule
